// File: rtl/r_return_buffer.sv
// r_return_buffer: R-channel return ring buffer, FWFT toward the master port.
// Optional macro R_BURST_CNT_EN adds burst_cnt/burst_avail (buffered bursts).
module r_return_buffer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 8,
  parameter int pending_depth = 4
) (
  input  logic                               ACLK,
  input  logic                               ARESETn,
  input  logic [ID_WIDTH-1:0]                in_RID,
  input  logic [DATA_WIDTH-1:0]              in_RDATA,
  input  logic [1:0]                         in_RRESP,
  input  logic                               in_RLAST,
  input  logic                               in_RVALID,
  output logic                               in_RREADY,
  output logic [ID_WIDTH-1:0]                RID,
  output logic [DATA_WIDTH-1:0]              RDATA,
  output logic [1:0]                         RRESP,
  output logic                               RLAST,
  output logic                               RVALID,
  input  logic                               RREADY,
`ifdef R_BURST_CNT_EN
  output logic [$clog2(pending_depth):0]     burst_cnt,
  output logic                               burst_avail,
`endif
  output logic [$clog2(pending_depth):0]     count,
  output logic                               full,
  output logic                               empty
);

  localparam int PTR_W = $clog2(pending_depth);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } entry_t;

  entry_t            mem_q [pending_depth];
  entry_t            wr_entry;
  entry_t            head;

  logic [PTR_W-1:0]  front_q, front_d;
  logic [PTR_W-1:0]  back_q, back_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push;
  logic              pop;

  // Status flags and handshakes, all from registered state.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CNT_W'(pending_depth));
    count     = count_q;
    in_RREADY = ARESETn & ~full;
    RVALID    = ~empty;
    push      = in_RVALID & in_RREADY;
    pop       = RVALID & RREADY;
    wr_entry  = '{id: in_RID, data: in_RDATA,
                  resp: in_RRESP, last: in_RLAST};
  end

  // Head entry presented to the master, zeroed while empty.
  always_comb begin
    head = '0;
    if (!empty) begin
      head = mem_q[front_q];
    end
    RID   = head.id;
    RDATA = head.data;
    RRESP = head.resp;
    RLAST = head.last;
  end

  // Pointer and occupancy next-state.
  always_comb begin
    front_d = front_q;
    back_d  = back_q;
    count_d = count_q;
    if (push) begin
      back_d = back_q + 1'b1;
    end
    if (pop) begin
      front_d = front_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      front_q <= '0;
      back_q  <= '0;
      count_q <= '0;
    end else begin
      front_q <= front_d;
      back_q  <= back_d;
      count_q <= count_d;
    end
  end

  // Beat storage; contents need no reset since count gates visibility.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_q[back_q] <= wr_entry;
    end
  end

`ifdef R_BURST_CNT_EN
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             burst_in;
  logic             burst_out;

  // Count of buffered beats carrying RLAST, i.e. complete bursts.
  always_comb begin
    burst_in    = push & in_RLAST;
    burst_out   = pop & head.last;
    burst_cnt_d = burst_cnt_q;
    unique case ({burst_in, burst_out})
      2'b10:   burst_cnt_d = burst_cnt_q + CNT_W'(1);
      2'b01:   burst_cnt_d = burst_cnt_q - CNT_W'(1);
      default: burst_cnt_d = burst_cnt_q;
    endcase
    burst_cnt   = burst_cnt_q;
    burst_avail = (burst_cnt_q != '0);
  end

  // Burst counter register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_r_return_buffer.sv
// tb_r_return_buffer: directed stimulus, queue scoreboard, negedge monitor.
// Build with +define+R_BURST_CNT_EN to exercise the burst counter.
module tb_r_return_buffer;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int PD = 4;
  localparam int CW = 3;

  typedef logic [IW+DW+2:0] beat_t;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [IW-1:0] in_RID = '0;
  logic [DW-1:0] in_RDATA = '0;
  logic [1:0]    in_RRESP = '0;
  logic          in_RLAST = 1'b0;
  logic          in_RVALID = 1'b0;
  logic          in_RREADY;
  logic [IW-1:0] RID;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          RVALID;
  logic          RREADY = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
`ifdef R_BURST_CNT_EN
  logic [CW-1:0] burst_cnt;
  logic          burst_avail;
`endif

  r_return_buffer #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .pending_depth(PD)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .in_RID(in_RID), .in_RDATA(in_RDATA),
    .in_RRESP(in_RRESP), .in_RLAST(in_RLAST),
    .in_RVALID(in_RVALID), .in_RREADY(in_RREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
    .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
`ifdef R_BURST_CNT_EN
    .burst_cnt(burst_cnt), .burst_avail(burst_avail),
`endif
    .count(count), .full(full), .empty(empty)
  );

  always #5 ACLK = ~ACLK;

  beat_t sb[$];
  int    checks = 0;
  int    failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare every accepted output beat.
  always @(negedge ACLK) begin
    if (ARESETn && RVALID && RREADY) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL r_unexpected actual=%0h required=none",
                 {RID, RDATA, RRESP, RLAST});
      end else begin
        chk("r_beat", 64'({RID, RDATA, RRESP, RLAST}),
            64'(sb.pop_front()));
      end
    end
  end

  task automatic push_beat(input logic [IW-1:0] id,
                           input logic [DW-1:0] data,
                           input logic [1:0] resp,
                           input logic last);
    bit acc = 0;
    in_RID    = id;
    in_RDATA  = data;
    in_RRESP  = resp;
    in_RLAST  = last;
    in_RVALID = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge ACLK);
      if (in_RREADY) begin
        acc = 1;
        sb.push_back({id, data, resp, last});
      end
      @(posedge ACLK);
      #1;
    end
    in_RVALID = 1'b0;
    if (!acc) chk("push_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    RREADY = 1'b1;
    for (int n = 0; n < 50 && RVALID; n++) begin
      @(posedge ACLK);
      #1;
    end
    chk("drain_empty", 64'(empty), 64'(1));
    chk("drain_sb", 64'(sb.size()), 64'(0));
    RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    // Reset state
    #12;
    chk("rst_rvalid", 64'(RVALID), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_in_rready", 64'(in_RREADY), 64'(0));
    chk("rst_rdata", 64'({RID, RDATA, RRESP, RLAST}), 64'(0));
`ifdef R_BURST_CNT_EN
    chk("rst_burst_cnt", 64'(burst_cnt), 64'(0));
`endif
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    chk("post_rst_in_rready", 64'(in_RREADY), 64'(1));

    // Test 1: single beat, hold while stalled
    push_beat(8'd3, 32'hA5A5_0001, 2'd0, 1'b1);
    chk("t1_rvalid", 64'(RVALID), 64'(1));
    chk("t1_rid", 64'(RID), 64'(3));
    chk("t1_rdata", 64'(RDATA), 64'hA5A5_0001);
    chk("t1_rlast", 64'(RLAST), 64'(1));
    chk("t1_count", 64'(count), 64'(1));
    repeat (5) begin
      @(negedge ACLK);
      chk("t1_hold", 64'({RVALID, RID, RDATA}),
          64'({1'b1, 8'd3, 32'hA5A5_0001}));
    end
    @(posedge ACLK);
    #1;
    RREADY = 1'b1;
    @(posedge ACLK);
    #1;
    RREADY = 1'b0;
    chk("t1_count_after_pop", 64'(count), 64'(0));
    chk("t1_rvalid_after_pop", 64'(RVALID), 64'(0));

    // Test 2 and 4: fill, blocked 5th beat, pop-only when full
    for (int i = 1; i <= 4; i++)
      push_beat(IW'(i), 32'h1000 + DW'(i), 2'(i), 1'b1);
    chk("t2_count", 64'(count), 64'(4));
    chk("t2_full", 64'(full), 64'(1));
    chk("t2_in_rready", 64'(in_RREADY), 64'(0));
    fork
      push_beat(8'd5, 32'h1005, 2'd1, 1'b0);
      begin
        repeat (3) begin
          @(negedge ACLK);
          chk("t2_blocked", 64'({count, in_RREADY}),
              64'({3'd4, 1'b0}));
        end
        @(posedge ACLK);
        #1;
        RREADY = 1'b1;
        @(posedge ACLK);
        #1;
        chk("t4_count_pop_only", 64'(count), 64'(3));
        chk("t4_in_rready", 64'(in_RREADY), 64'(1));
        chk("t4_full", 64'(full), 64'(0));
      end
    join
    drain();

    // Test 3: continuous streaming, pointers wrap
    RREADY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = 32'hBEEF_0000 + DW'(i);
      in_RID    = IW'(8'h40 + i);
      in_RDATA  = d;
      in_RRESP  = 2'(i);
      in_RLAST  = (i % 3 == 2);
      in_RVALID = 1'b1;
      @(negedge ACLK);
      if (i > 0) begin
        chk("t3_count", 64'(count), 64'(1));
        chk("t3_rvalid", 64'(RVALID), 64'(1));
      end
      chk("t3_in_rready", 64'(in_RREADY), 64'(1));
      sb.push_back({IW'(8'h40 + i), d, 2'(i), (i % 3 == 2)});
      @(posedge ACLK);
      #1;
    end
    in_RVALID = 1'b0;
    drain();

    // Test 5: asynchronous reset with data stored
    for (int i = 0; i < 3; i++)
      push_beat(IW'(8'h70 + i), 32'hCAFE_0000 + DW'(i), 2'd2, 1'b1);
    chk("t5_count", 64'(count), 64'(3));
    @(posedge ACLK);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("t5_rvalid", 64'(RVALID), 64'(0));
    chk("t5_count_rst", 64'(count), 64'(0));
    chk("t5_in_rready", 64'(in_RREADY), 64'(0));
    sb.delete();
    #3;
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    chk("t5_in_rready_rel", 64'(in_RREADY), 64'(1));
    chk("t5_rvalid_rel", 64'(RVALID), 64'(0));
    chk("t5_rdata_rel", 64'({RID, RDATA, RRESP, RLAST}), 64'(0));

`ifdef R_BURST_CNT_EN
    // Test 6: bursts of length 2 and 1
    push_beat(8'h11, 32'h0000_0A01, 2'd0, 1'b0);
    push_beat(8'h11, 32'h0000_0A02, 2'd0, 1'b1);
    push_beat(8'h12, 32'h0000_0B01, 2'd0, 1'b1);
    chk("t6_burst_cnt", 64'(burst_cnt), 64'(2));
    chk("t6_burst_avail", 64'(burst_avail), 64'(1));
    RREADY = 1'b1;
    @(posedge ACLK);
    #1;
    RREADY = 1'b0;
    chk("t6_burst_cnt_pop1", 64'(burst_cnt), 64'(2));
    RREADY = 1'b1;
    @(posedge ACLK);
    #1;
    RREADY = 1'b0;
    chk("t6_burst_cnt_pop2", 64'(burst_cnt), 64'(1));
    chk("t6_burst_avail2", 64'(burst_avail), 64'(1));
    drain();
    chk("t6_burst_cnt_end", 64'(burst_cnt), 64'(0));
    chk("t6_burst_avail_end", 64'(burst_avail), 64'(0));
`endif

    chk("end_sb_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
